// File: rtl/enigma_core.sv
// enigma_core: 3-rotor Enigma (rotors I-V, UKW-B/C, rings at A, no plugboard), one letter per 10 cycles.
// Optional ENIGMA_POS_OUT_EN adds rotor_pos_out showing the live rotor positions.
module enigma_core #(
  parameter int REFLECTOR = 0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rotor_valid_in,
  input  logic        letter_valid_in,
  input  logic [8:0]  rotor_select_in,
  input  logic [14:0] rotor_initial_in,
  input  logic [4:0]  char_in,
`ifdef ENIGMA_POS_OUT_EN
  output logic [14:0] rotor_pos_out,
`endif
  output logic        ready_out,
  output logic        char_valid_out,
  output logic [4:0]  char_out
);

  localparam int unsigned CW       = 5;
  localparam int unsigned SW       = 3;
  localparam int unsigned PW       = 3 * CW;
  localparam int unsigned SELW     = 3 * SW;
  localparam int unsigned ALPHA    = 26;
  localparam int unsigned ROT_MAX  = 4;
  localparam logic [SELW-1:0] SEL_RST = 9'b000_001_010;

  typedef enum logic [3:0] {
    S_IDLE, S_STEP, S_FWD0, S_FWD1, S_FWD2, S_REFL, S_BWD0, S_BWD1, S_BWD2, S_DONE
  } state_e;

  // Rotor wirings I..V, forward and inverse, indexed by entry contact.
  localparam logic [CW-1:0] ROT_FWD [5][26] = '{
    '{5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
      5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9},
    '{5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
      5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4},
    '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
      5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14},
    '{5'd4, 5'd18, 5'd14, 5'd21, 5'd15, 5'd25, 5'd9, 5'd0, 5'd24, 5'd16, 5'd20, 5'd8, 5'd17,
      5'd7, 5'd23, 5'd11, 5'd13, 5'd5, 5'd19, 5'd6, 5'd10, 5'd3, 5'd2, 5'd12, 5'd22, 5'd1},
    '{5'd21, 5'd25, 5'd1, 5'd17, 5'd6, 5'd8, 5'd19, 5'd24, 5'd20, 5'd15, 5'd18, 5'd3, 5'd13,
      5'd7, 5'd11, 5'd23, 5'd0, 5'd22, 5'd12, 5'd9, 5'd16, 5'd14, 5'd5, 5'd4, 5'd2, 5'd10}
  };

  localparam logic [CW-1:0] ROT_INV [5][26] = '{
    '{5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
      5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9},
    '{5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd22, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
      5'd19, 5'd24, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd23, 5'd12, 5'd8, 5'd21, 5'd18},
    '{5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
      5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9, 5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12},
    '{5'd7, 5'd25, 5'd22, 5'd21, 5'd0, 5'd17, 5'd19, 5'd13, 5'd11, 5'd6, 5'd20, 5'd15, 5'd23,
      5'd16, 5'd2, 5'd4, 5'd9, 5'd12, 5'd1, 5'd18, 5'd10, 5'd3, 5'd24, 5'd14, 5'd8, 5'd5},
    '{5'd16, 5'd2, 5'd24, 5'd11, 5'd23, 5'd22, 5'd4, 5'd13, 5'd5, 5'd19, 5'd25, 5'd14, 5'd18,
      5'd12, 5'd21, 5'd9, 5'd20, 5'd3, 5'd10, 5'd6, 5'd8, 5'd0, 5'd17, 5'd15, 5'd7, 5'd1}
  };

  localparam logic [CW-1:0] REFL_B [26] = '{
    5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
    5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};

  localparam logic [CW-1:0] REFL_C [26] = '{
    5'd5, 5'd21, 5'd15, 5'd9, 5'd8, 5'd0, 5'd14, 5'd24, 5'd4, 5'd3, 5'd17, 5'd25, 5'd23,
    5'd22, 5'd6, 5'd2, 5'd19, 5'd10, 5'd20, 5'd16, 5'd18, 5'd1, 5'd13, 5'd12, 5'd7, 5'd11};

  // Position just before the rotor carries its left neighbour.
  localparam logic [CW-1:0] NOTCH [5] = '{5'd16, 5'd4, 5'd21, 5'd9, 5'd25};

  function automatic logic [CW-1:0] inc26(input logic [CW-1:0] p);
    return (p == CW'(ALPHA - 1)) ? '0 : p + CW'(1);
  endfunction

  function automatic logic [CW-1:0] fold26(input logic [CW-1:0] p);
    return (p >= CW'(ALPHA)) ? p - CW'(ALPHA) : p;
  endfunction

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [CW-1:0]   c_q, c_d;
  logic [CW-1:0]   char_out_q, char_out_d;
  logic            char_valid_q, char_valid_d;
  logic            ready_q, ready_d;

  logic [SW-1:0]   rot_c;
  logic [CW-1:0]   rpos_c;
  logic [CW:0]     sum_c;
  logic [CW-1:0]   wire_c;
  logic [CW-1:0]   pass_c;
  logic [CW-1:0]   refl_c;
  logic            bwd_c;
  logic [PW-1:0]   step_pos_c;
  logic            r_notch_c, m_notch_c;
  logic            cfg_ok_c;
  logic [PW-1:0]   cfg_pos_c;

  // One rotor pass: choose rotor by state, shift in by position, look up, shift back out.
  always_comb begin
    rot_c  = sel_q[2:0];
    rpos_c = pos_q[4:0];
    case (state_q)
      S_FWD1, S_BWD1: begin rot_c = sel_q[5:3]; rpos_c = pos_q[9:5];   end
      S_FWD2, S_BWD0: begin rot_c = sel_q[8:6]; rpos_c = pos_q[14:10]; end
      default:        begin rot_c = sel_q[2:0]; rpos_c = pos_q[4:0];   end
    endcase
    bwd_c = (state_q == S_BWD0) || (state_q == S_BWD1) || (state_q == S_BWD2);
    sum_c = (CW+1)'(c_q) + (CW+1)'(rpos_c);
    if (sum_c >= (CW+1)'(ALPHA)) sum_c = sum_c - (CW+1)'(ALPHA);
    wire_c = bwd_c ? ROT_INV[rot_c][sum_c[CW-1:0]] : ROT_FWD[rot_c][sum_c[CW-1:0]];
    if (wire_c >= rpos_c) pass_c = wire_c - rpos_c;
    else                  pass_c = CW'((CW+1)'(wire_c) + (CW+1)'(ALPHA) - (CW+1)'(rpos_c));
    refl_c = (REFLECTOR == 1) ? REFL_C[c_q] : REFL_B[c_q];
  end

  // Stepping with the middle-rotor double step.
  always_comb begin
    r_notch_c  = (pos_q[4:0] == NOTCH[sel_q[2:0]]);
    m_notch_c  = (pos_q[9:5] == NOTCH[sel_q[5:3]]);
    step_pos_c = {m_notch_c ? inc26(pos_q[14:10]) : pos_q[14:10],
                  (r_notch_c || m_notch_c) ? inc26(pos_q[9:5]) : pos_q[9:5],
                  inc26(pos_q[4:0])};
    cfg_ok_c   = (rotor_select_in[2:0] <= SW'(ROT_MAX)) &&
                 (rotor_select_in[5:3] <= SW'(ROT_MAX)) &&
                 (rotor_select_in[8:6] <= SW'(ROT_MAX));
    cfg_pos_c  = {fold26(rotor_initial_in[14:10]), fold26(rotor_initial_in[9:5]),
                  fold26(rotor_initial_in[4:0])};
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    pos_d        = pos_q;
    c_d          = c_q;
    char_out_d   = char_out_q;
    char_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rotor_valid_in) begin
          if (cfg_ok_c) begin
            sel_d = rotor_select_in;
            pos_d = cfg_pos_c;
          end
        end else if (letter_valid_in && (char_in < CW'(ALPHA))) begin
          c_d     = char_in;
          state_d = S_STEP;
        end
      end
      S_STEP: begin pos_d = step_pos_c; state_d = S_FWD0; end
      S_FWD0: begin c_d = pass_c; state_d = S_FWD1; end
      S_FWD1: begin c_d = pass_c; state_d = S_FWD2; end
      S_FWD2: begin c_d = pass_c; state_d = S_REFL; end
      S_REFL: begin c_d = refl_c; state_d = S_BWD0; end
      S_BWD0: begin c_d = pass_c; state_d = S_BWD1; end
      S_BWD1: begin c_d = pass_c; state_d = S_BWD2; end
      S_BWD2: begin c_d = pass_c; state_d = S_DONE; end
      S_DONE: begin
        char_out_d   = c_q;
        char_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      sel_q        <= SEL_RST;
      pos_q        <= '0;
      c_q          <= '0;
      char_out_q   <= '0;
      char_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      pos_q        <= pos_d;
      c_q          <= c_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign ready_out      = ready_q;
  assign char_valid_out = char_valid_q;
  assign char_out       = char_out_q;
`ifdef ENIGMA_POS_OUT_EN
  assign rotor_pos_out  = pos_q;
`endif

endmodule

// File: tb/tb_enigma_core.sv
// tb_enigma_core: directed and randomized checks of enigma_core against a string-table Enigma model.
module tb_enigma_core;
  localparam int REFL_SEL = 0;

  logic        clk_in;
  logic        rst_n_in;
  logic        rotor_valid_in;
  logic        letter_valid_in;
  logic [8:0]  rotor_select_in;
  logic [14:0] rotor_initial_in;
  logic [4:0]  char_in;
  logic        ready_out;
  logic        char_valid_out;
  logic [4:0]  char_out;
`ifdef ENIGMA_POS_OUT_EN
  logic [14:0] rotor_pos_out;
`endif

  enigma_core #(.REFLECTOR(REFL_SEL)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .rotor_valid_in   (rotor_valid_in),
    .letter_valid_in  (letter_valid_in),
    .rotor_select_in  (rotor_select_in),
    .rotor_initial_in (rotor_initial_in),
    .char_in          (char_in),
`ifdef ENIGMA_POS_OUT_EN
    .rotor_pos_out    (rotor_pos_out),
`endif
    .ready_out        (ready_out),
    .char_valid_out   (char_valid_out),
    .char_out         (char_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int passed = 0;
  int total  = 0;

  // Reference model: historical wirings as letter strings; index 0 = left, 2 = right.
  string rot_w [5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                       "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                       "VZBRGITYUPSDNHLXAWMJQOFECK"};
  string refl_w [2] = '{"YRUHQSLDPXNGOKMIEBFZCWVJAT", "FVPJIAOYEDRZXWGCTKUQSBNMHL"};
  string notch_s = "QEVJZ";
  int m_rot [3];
  int m_pos [3];

  function automatic int wire_of(input int r, input int i);
    string w;
    w = rot_w[r];
    return int'(w[i]) - 65;
  endfunction

  function automatic int notch_of(input int r);
    return int'(notch_s[r]) - 65;
  endfunction

  function automatic int through(input int r, input int p, input int c, input bit inv);
    int e;
    int o;
    e = (c + p) % 26;
    o = 0;
    if (!inv) o = wire_of(r, e);
    else for (int j = 0; j < 26; j++) if (wire_of(r, j) == e) o = j;
    return (o - p + 26) % 26;
  endfunction

  function automatic void model_reset();
    m_rot[0] = 0; m_rot[1] = 1; m_rot[2] = 2;
    m_pos[0] = 0; m_pos[1] = 0; m_pos[2] = 0;
  endfunction

  function automatic void model_cfg(input logic [8:0] sel, input logic [14:0] pos);
    if (sel[8:6] <= 4 && sel[5:3] <= 4 && sel[2:0] <= 4) begin
      m_rot[0] = int'(sel[8:6]);
      m_rot[1] = int'(sel[5:3]);
      m_rot[2] = int'(sel[2:0]);
      m_pos[0] = int'(pos[14:10]) % 26;
      m_pos[1] = int'(pos[9:5]) % 26;
      m_pos[2] = int'(pos[4:0]) % 26;
    end
  endfunction

  function automatic void model_step();
    bit r_turn;
    bit m_turn;
    r_turn = (m_pos[2] == notch_of(m_rot[2]));
    m_turn = (m_pos[1] == notch_of(m_rot[1]));
    m_pos[2] = (m_pos[2] + 1) % 26;
    if (r_turn || m_turn) m_pos[1] = (m_pos[1] + 1) % 26;
    if (m_turn) m_pos[0] = (m_pos[0] + 1) % 26;
  endfunction

  function automatic int model_cipher(input int c);
    int x;
    string rs;
    rs = (REFL_SEL == 1) ? refl_w[1] : refl_w[0];
    x = c;
    for (int k = 2; k >= 0; k--) x = through(m_rot[k], m_pos[k], x, 1'b0);
    x = int'(rs[x]) - 65;
    for (int k = 0; k < 3; k++) x = through(m_rot[k], m_pos[k], x, 1'b1);
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send_cfg(input logic [8:0] sel, input logic [14:0] pos);
    rotor_select_in  = sel;
    rotor_initial_in = pos;
    rotor_valid_in   = 1'b1;
    @(negedge clk_in);
    rotor_valid_in   = 1'b0;
    model_cfg(sel, pos);
  endtask

  // Encrypt one letter; optionally inject a stray letter pulse while the core is busy.
  task automatic press(input int c, input int inject_at, output int res);
    int n;
    int exp;
    bit got;
    model_step();
    exp = model_cipher(c);
    char_in = 5'(c);
    letter_valid_in = 1'b1;
    @(negedge clk_in);
    letter_valid_in = 1'b0;
    n = 1;
    check("busy_ready", 32'(ready_out), 0);
    got = char_valid_out;
    while (!got && n < 20) begin
      if (n == inject_at) begin
        letter_valid_in = 1'b1;
        char_in = 5'($urandom_range(0, 25));
      end
      @(negedge clk_in);
      letter_valid_in = 1'b0;
      n++;
`ifdef ENIGMA_POS_OUT_EN
      if (n == 2) check("pos_out", 32'(rotor_pos_out), m_pos[0] * 1024 + m_pos[1] * 32 + m_pos[2]);
`endif
      got = char_valid_out;
    end
    check("latency", n, 10);
    check("cipher", 32'(char_out), exp);
    check("ready_back", 32'(ready_out), 1);
    res = int'(char_out);
    @(negedge clk_in);
    check("pulse_width", 32'(char_valid_out), 0);
    check("char_held", 32'(char_out), res);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int pulses;
    int not_ready;
    pulses = 0;
    not_ready = 0;
    repeat (cycles) begin
      @(negedge clk_in);
      if (char_valid_out) pulses++;
      if (!ready_out) not_ready++;
    end
    check({tag, "_pulses"}, pulses, 0);
    check({tag, "_ready"}, not_ready, 0);
  endtask

  initial begin
    int res;
    int aaaaa [5];
    int rec [26];
    logic [8:0]  sel;
    logic [14:0] pos;

    aaaaa = '{1, 3, 25, 6, 14};
    rst_n_in = 1'b0;
    rotor_valid_in = 1'b0;
    letter_valid_in = 1'b0;
    rotor_select_in = '0;
    rotor_initial_in = '0;
    char_in = '0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check("rst_ready", 32'(ready_out), 1);
    check("rst_valid", 32'(char_valid_out), 0);
    check("rst_char", 32'(char_out), 0);
`ifdef ENIGMA_POS_OUT_EN
    check("rst_pos", 32'(rotor_pos_out), 0);
`endif
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // AAAAA from AAA with I/II/III
    for (int i = 0; i < 5; i++) begin
      press(0, -1, res);
      check("aaaaa", res, aaaaa[i]);
    end

    // Double step from ADU
    send_cfg(9'b000_001_010, {5'd0, 5'd3, 5'd20});
    for (int i = 0; i < 3; i++) press(int'($urandom_range(0, 25)), -1, res);

    // Reciprocity and no letter maps to itself
    sel = {3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
    pos = 15'($urandom_range(0, 32767));
    send_cfg(sel, pos);
    for (int i = 0; i < 26; i++) begin
      press(i, -1, rec[i]);
      check("no_self", 32'(rec[i] == i), 0);
    end
    send_cfg(sel, pos);
    for (int i = 0; i < 26; i++) begin
      press(rec[i], -1, res);
      check("reciprocal", res, i);
    end

    // Out-of-range letter is dropped
    char_in = 5'd27;
    letter_valid_in = 1'b1;
    @(negedge clk_in);
    letter_valid_in = 1'b0;
    expect_quiet("bad_char", 12);
    press(int'($urandom_range(0, 25)), -1, res);

    // Bad select field leaves the configuration alone
    send_cfg(9'b000_001_010, 15'd0);
    send_cfg(9'b110_001_010, {5'd7, 5'd8, 5'd9});
    press(0, -1, res);
    check("bad_sel_a2b", res, 1);

    // Position 30 folds to 4
    send_cfg(9'b000_001_010, {5'd0, 5'd0, 5'd30});
    press(int'($urandom_range(0, 25)), -1, res);

    // Stray letter while busy
    press(int'($urandom_range(0, 25)), 3, res);
    expect_quiet("busy_inject", 12);

    // Reset mid-encryption
    char_in = 5'd4;
    letter_valid_in = 1'b1;
    @(negedge clk_in);
    letter_valid_in = 1'b0;
    repeat (4) @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check("abort_ready", 32'(ready_out), 1);
    check("abort_valid", 32'(char_valid_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    model_reset();
    expect_quiet("abort", 12);
    press(0, -1, res);
    check("abort_a2b", res, 1);

    // Random configs (some invalid) and letters
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) send_cfg(9'($urandom_range(0, 511)), 15'($urandom_range(0, 32767)));
      press(int'($urandom_range(0, 25)), -1, res);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
